tdc_quad_reader: RTL
====================

Name: tdc_quad_reader

Overview:
- Controller and reader for the quadrature-clocked oscillator counter in the TDC path.
- Opens a measurement window of programmable length by driving the counter's enable and clear.
- Waits for the counter's has-value flag, then captures a stable count into the clk domain.
- Presents the result on a valid/ready interface to the Sigma Delta DAQ sample logic.

Parameters:
- BIT_COUNT, 32, width of counter value and output count.
- WIN_W, 16, width of window_len.
- SYNC_STAGES, 2, flip-flop stages on tdc_has_value (minimum 2).
- SETTLE_CYCLES, 2, clk cycles between synchronized has-value and first count sample.
- TIMEOUT_CYCLES, 1024, maximum clk cycles spent waiting for has-value.
- MAX_RETRY, 3, extra sample pairs attempted before flagging instability.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle measurement request.
- window_len  input  WIN_W  enable window length in clk cycles; sampled on accepted start.
- busy  output  1  high from accepted start until output handshake completes.
- tdc_enable  output  1  drives the counter enable.
- tdc_clear  output  1  drives the counter's active-high reset.
- tdc_count  input  BIT_COUNT  binary count from the counter; asynchronous to clk.
- tdc_has_value  input  1  counter has-value flag; asynchronous.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_count  output  BIT_COUNT  captured count.
- out_error  output  1  qualifies out_valid: 1 means timeout or unstable count.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; all counters cleared.
  - tdc_enable=0, tdc_clear=1, busy=0, out_valid=0, out_count=0, out_error=0.
  - Synchronizer flops cleared.
- IDLE:
  - tdc_clear=0.
  - start=1 → latch window_len (value 0 is treated as 1), set busy=1, go to CLEAR.
- CLEAR: tdc_clear=1 for exactly 1 cycle, then go to WINDOW.
- WINDOW:
  - tdc_enable=1 for exactly the latched window length, counted in clk cycles.
  - Then go to WAIT_VAL with tdc_enable=0.
- WAIT_VAL:
  - Wait for has_sync=1 (tdc_has_value after SYNC_STAGES flops).
  - If has_sync=1 is seen within TIMEOUT_CYCLES → go to SETTLE.
  - Otherwise → out_count=0, out_error=1, go to OUT.
  - A has_sync level already high on entry is ignored until it has been seen low at least once in this measurement (guards against a stale flag).
- SETTLE: wait SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - Register tdc_count on two consecutive cycles (s0, s1).
  - s0==s1 → out_count=s1, out_error=0, go to OUT.
  - Otherwise retry, up to MAX_RETRY extra pairs.
  - Retries exhausted → out_count=last s1, out_error=1, go to OUT.
- OUT:
  - out_valid=1; out_count and out_error held stable.
  - Transfer occurs on out_valid & out_ready.
  - Next cycle: out_valid=0, busy=0, state IDLE.
  - out_ready may already be high on entry, in which case the transfer completes in the first OUT cycle.
- Latency, no retry, flag rising immediately after enable falls:
  - start at cycle 0: CLEAR at cycle 1, tdc_enable high during cycles 2..1+N.
  - out_valid no earlier than 1+N+SYNC_STAGES+SETTLE_CYCLES+2.
- start while busy=1: ignored. No queueing, no restart.
- Mid-operation reset: immediate return to reset values; tdc_enable drops asynchronously.
- Width rules:
  - Window and timeout counters saturate and do not wrap.
  - Timeout counter width is clog2(TIMEOUT_CYCLES+1).
- tdc_count is never used outside SAMPLE; the equality check is the only CDC protection for the multi-bit value.

Decomposition:
- Package tdc_pkg holds:
  - the state enum: IDLE, CLEAR, WINDOW, WAIT_VAL, SETTLE, SAMPLE, OUT;
  - the localparam helpers for counter widths;
  - a shared RESULT_OK/RESULT_ERR encoding.
- One sub-module, bit_synchronizer, parameterized by SYNC_STAGES, with asynchronous active-low reset. Used for tdc_has_value.

Test Plan:
- Nominal:
  - Stimulus: window_len=10, model counter increments while enabled, counts to 0x2A, raises has_value 3 cycles after enable falls; out_ready=1.
  - Response: tdc_enable high exactly 10 cycles; out_valid one cycle; out_count=0x2A; out_error=0; busy low the cycle after.
- Timeout: has_value never rises → out_valid with out_count=0, out_error=1 exactly TIMEOUT_CYCLES after entering WAIT_VAL.
- Unstable count:
  - Model toggles tdc_count every cycle during SAMPLE → 4 sample pairs, then out_error=1.
  - Model stabilizes on second pair → out_count equals the stable value, out_error=0.
- Backpressure and start:
  - Stimulus: out_ready=0 for 20 cycles; pulse start during OUT.
  - Response: out_valid and out_count held; start ignored; no second tdc_clear pulse; transfer on first out_ready=1.
- Window length zero: window_len=0 → tdc_enable high exactly 1 cycle.
- Reset mid-WINDOW:
  - Stimulus: reset low asynchronously.
  - Response: tdc_enable=0 and tdc_clear=1 immediately; after release, a start runs a full clean measurement.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types for the TDC quadrature counter reader: FSM states, result encoding, counter width helper.
// Pure declarations; no timing or flow control of its own.
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WINDOW,
        WAIT_VAL,
        SETTLE,
        SAMPLE,
        OUT
    } state_t;

    localparam logic RESULT_OK  = 1'b0;
    localparam logic RESULT_ERR = 1'b1;

    localparam int MIN_SYNC_STAGES = 2;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: STAGES clk cycles (at least two); no backpressure.
module bit_synchronizer
    import tdc_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/tdc_quad_reader.sv
// Runs one TDC measurement per start: clear, timed enable window, wait for has-value, stable capture.
// Latency: window + sync + settle + sample pairs; result held on out_valid until out_ready.
module tdc_quad_reader
    import tdc_pkg::*;
#(
    parameter int BIT_COUNT      = 32,
    parameter int WIN_W          = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIN_W-1:0]     window_len,
    output logic                 busy,
    output logic                 tdc_enable,
    output logic                 tdc_clear,
    input  logic [BIT_COUNT-1:0] tdc_count,
    input  logic                 tdc_has_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_COUNT-1:0] out_count,
    output logic                 out_error
);

    localparam int TO_W = cnt_w(TIMEOUT_CYCLES);
    localparam int ST_W = cnt_w(SETTLE_CYCLES);
    localparam int RT_W = cnt_w(MAX_RETRY);

    state_t               state, next_state;
    logic [WIN_W-1:0]     win_len, win_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [ST_W-1:0]      settle_cnt;
    logic [RT_W-1:0]      retry_cnt;
    logic                 phase;
    logic                 seen_low;
    logic                 has_sync;
    logic                 sample_match;
    logic [BIT_COUNT-1:0] s0;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_has_sync (
        .clk  (clk),
        .reset(reset),
        .d    (tdc_has_value),
        .q    (has_sync)
    );

    // Second sample of a pair is compared straight off the port and registered into out_count.
    assign sample_match = phase && (s0 == tdc_count);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = CLEAR;
            CLEAR:    next_state = WINDOW;
            WINDOW:   if (win_cnt == win_len - WIN_W'(1)) next_state = WAIT_VAL;
            WAIT_VAL: begin
                if (has_sync && seen_low) begin
                    next_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    next_state = OUT;
                end
            end
            SETTLE:   if (settle_cnt == ST_W'(SETTLE_CYCLES - 1)) next_state = SAMPLE;
            SAMPLE:   if (phase && (sample_match || retry_cnt == RT_W'(MAX_RETRY))) next_state = OUT;
            OUT:      if (out_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            win_len    <= '0;
            win_cnt    <= '0;
            to_cnt     <= '0;
            settle_cnt <= '0;
            retry_cnt  <= '0;
            phase      <= 1'b0;
            seen_low   <= 1'b0;
            s0         <= '0;
            tdc_enable <= 1'b0;
            tdc_clear  <= 1'b1;
            out_count  <= '0;
            out_error  <= RESULT_OK;
        end else begin
            state      <= next_state;
            tdc_enable <= (next_state == WINDOW);
            tdc_clear  <= (next_state == CLEAR);

            if (state == IDLE && start) begin
                win_len <= (window_len == '0) ? WIN_W'(1) : window_len;
            end

            if (state == WINDOW && next_state == WINDOW) begin
                if (win_cnt != '1) win_cnt <= win_cnt + WIN_W'(1);
            end else begin
                win_cnt <= '0;
            end

            if (state == WAIT_VAL && next_state == WAIT_VAL) begin
                if (to_cnt != '1) to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            if (state == SETTLE && next_state == SETTLE) begin
                if (settle_cnt != '1) settle_cnt <= settle_cnt + ST_W'(1);
            end else begin
                settle_cnt <= '0;
            end

            // A flag left high by the previous measurement must drop before it is trusted.
            if (state == IDLE) begin
                seen_low <= 1'b0;
            end else if (!has_sync) begin
                seen_low <= 1'b1;
            end

            if (state != SAMPLE) begin
                phase     <= 1'b0;
                retry_cnt <= '0;
            end else if (!phase) begin
                s0    <= tdc_count;
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (retry_cnt != '1) retry_cnt <= retry_cnt + RT_W'(1);
            end

            if (state == WAIT_VAL && next_state == OUT) begin
                out_count <= '0;
                out_error <= RESULT_ERR;
            end else if (state == SAMPLE && next_state == OUT) begin
                out_count <= tdc_count;
                out_error <= sample_match ? RESULT_OK : RESULT_ERR;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);

endmodule
